// File: rtl/ibf_cfg_loader_if.sv
// Host command stream for the inverse-butterfly configuration loader.
// The host drives valid/data; the loader answers with ready.
interface ibf_cfg_loader_if;
  logic        host_valid_i;
  logic        host_ready_o;
  logic [31:0] host_data_i;

  modport master (output host_valid_i, output host_data_i, input host_ready_o);
  modport slave  (input host_valid_i, input host_data_i, output host_ready_o);
endinterface

// File: rtl/ibf_cfg_loader.sv
// Decodes header/data beats from the host stream into 64-bit slice writes
// for the extractor's BF-network store (_2_2) and output-mux store (_2_1).
module ibf_cfg_loader #(
  parameter int NUM_SLICE_2_2 = 224,
  parameter int NUM_SLICE_2_1 = 10
) (
  input  logic                clk,
  input  logic                rst,
  ibf_cfg_loader_if.slave     host,
  output logic [7:0]          sram_sel_2_2,
  output logic [1:0]          wr_addr_2_2,
  output logic                wr_en_2_2,
  output logic [63:0]         wr_cfg_2_2,
  output logic [3:0]          sram_sel_2_1,
  output logic [1:0]          wr_addr_2_1,
  output logic                wr_en_2_1,
  output logic [63:0]         wr_cfg_2_1,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  input  logic                err_clr_i
);

  typedef enum logic [1:0] {IDLE, LO, HI, DRAIN} state_t;

  localparam logic [8:0] LIM_2_2 = 9'(NUM_SLICE_2_2);
  localparam logic [8:0] LIM_2_1 = 9'(NUM_SLICE_2_1);

  state_t      state, state_nxt;
  logic        tgt, tgt_nxt;
  logic [1:0]  addr_q, addr_nxt;
  logic [7:0]  cur_sel, cur_sel_nxt;
  logic [8:0]  rem, rem_nxt;
  logic [31:0] lo_reg, lo_nxt;
  logic        wr_fire, last_wr, err_set;

  logic        accept;
  logic [1:0]  hdr_tgt, hdr_addr;
  logic [7:0]  hdr_start, hdr_n;
  logic [8:0]  hdr_end, hdr_lim;
  logic        hdr_bad;

  assign accept    = host.host_valid_i & host.host_ready_o;
  assign hdr_tgt   = host.host_data_i[31:30];
  assign hdr_addr  = host.host_data_i[29:28];
  assign hdr_start = host.host_data_i[27:20];
  assign hdr_n     = host.host_data_i[19:12];
  // Nine-bit sum so start+N cannot wrap before the range compare.
  assign hdr_end   = {1'b0, hdr_start} + {1'b0, hdr_n};
  assign hdr_lim   = hdr_tgt[0] ? LIM_2_1 : LIM_2_2;
  assign hdr_bad   = hdr_tgt[1] || (hdr_n == 8'd0) || (hdr_end > hdr_lim);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    tgt_nxt     = tgt;
    addr_nxt    = addr_q;
    cur_sel_nxt = cur_sel;
    rem_nxt     = rem;
    lo_nxt      = lo_reg;
    wr_fire     = 1'b0;
    last_wr     = 1'b0;
    err_set     = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (hdr_bad) begin
            err_set = 1'b1;
            // A bad header with a nonzero count still owns its data beats.
            if (hdr_n != 8'd0) begin
              rem_nxt   = {hdr_n, 1'b0};
              state_nxt = DRAIN;
            end
          end else begin
            tgt_nxt     = hdr_tgt[0];
            addr_nxt    = hdr_addr;
            cur_sel_nxt = hdr_start;
            rem_nxt     = {1'b0, hdr_n};
            state_nxt   = LO;
          end
        end
        LO: begin
          lo_nxt    = host.host_data_i;
          state_nxt = HI;
        end
        HI: begin
          wr_fire     = 1'b1;
          cur_sel_nxt = cur_sel + 8'd1;
          rem_nxt     = rem - 9'd1;
          if (rem == 9'd1) begin
            last_wr   = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = LO;
          end
        end
        DRAIN: begin
          rem_nxt = rem - 9'd1;
          if (rem == 9'd1) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt          <= 1'b0;
      addr_q       <= '0;
      cur_sel      <= '0;
      rem          <= '0;
      lo_reg       <= '0;
      host.host_ready_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      wr_en_2_2    <= 1'b0;
      sram_sel_2_2 <= '0;
      wr_addr_2_2  <= '0;
      wr_cfg_2_2   <= '0;
      wr_en_2_1    <= 1'b0;
      sram_sel_2_1 <= '0;
      wr_addr_2_1  <= '0;
      wr_cfg_2_1   <= '0;
    end else begin
      tgt          <= tgt_nxt;
      addr_q       <= addr_nxt;
      cur_sel      <= cur_sel_nxt;
      rem          <= rem_nxt;
      lo_reg       <= lo_nxt;
      host.host_ready_o <= 1'b1;
      busy_o       <= (state_nxt != IDLE);
      done_o       <= last_wr;
      err_o        <= err_set | (err_o & ~err_clr_i);
      wr_en_2_2    <= wr_fire & ~tgt;
      wr_en_2_1    <= wr_fire & tgt;
      // Store-side sel/addr/cfg only move on a write and hold otherwise.
      if (wr_fire && !tgt) begin
        sram_sel_2_2 <= cur_sel;
        wr_addr_2_2  <= addr_q;
        wr_cfg_2_2   <= {host.host_data_i, lo_reg};
      end
      if (wr_fire && tgt) begin
        sram_sel_2_1 <= cur_sel[3:0];
        wr_addr_2_1  <= addr_q;
        wr_cfg_2_1   <= {host.host_data_i, lo_reg};
      end
    end
  end

endmodule

// File: tb/tb_ibf_cfg_loader.sv
// Bench for ibf_cfg_loader: directed scenarios plus randomized commands
// checked against a command-level model of the expected slice writes.
module tb_ibf_cfg_loader;

  localparam int NS22 = 224;
  localparam int NS21 = 10;

  typedef struct packed {
    logic        tgt;
    logic [7:0]  sel;
    logic [1:0]  addr;
    logic [63:0] cfg;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        err_clr_i = 1'b0;
  logic [7:0]  sram_sel_2_2;
  logic [1:0]  wr_addr_2_2;
  logic        wr_en_2_2;
  logic [63:0] wr_cfg_2_2;
  logic [3:0]  sram_sel_2_1;
  logic [1:0]  wr_addr_2_1;
  logic        wr_en_2_1;
  logic [63:0] wr_cfg_2_1;
  logic        busy_o, done_o, err_o;

  ibf_cfg_loader_if host_if ();

  ibf_cfg_loader #(.NUM_SLICE_2_2(NS22), .NUM_SLICE_2_1(NS21)) dut (
    .clk(clk), .rst(rst), .host(host_if.slave),
    .sram_sel_2_2(sram_sel_2_2), .wr_addr_2_2(wr_addr_2_2),
    .wr_en_2_2(wr_en_2_2), .wr_cfg_2_2(wr_cfg_2_2),
    .sram_sel_2_1(sram_sel_2_1), .wr_addr_2_1(wr_addr_2_1),
    .wr_en_2_1(wr_en_2_1), .wr_cfg_2_1(wr_cfg_2_1),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_clr_i(err_clr_i)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_fail = 0;
  wr_t  obs_q[$];
  wr_t  exp_q[$];
  int   done_cnt = 0, exp_done = 0;
  int   both_hi = 0, consec = 0, done_alone = 0, busy_drop = 0;
  logic track_busy = 1'b0;
  logic exp_err = 1'b0;
  logic prev_wr = 1'b0;

  // Passive recorder of every store write and protocol anomaly.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en_2_2) obs_q.push_back(wr_t'{1'b0, sram_sel_2_2, wr_addr_2_2, wr_cfg_2_2});
      if (wr_en_2_1) obs_q.push_back(wr_t'{1'b1, {4'b0, sram_sel_2_1}, wr_addr_2_1, wr_cfg_2_1});
      if (wr_en_2_2 && wr_en_2_1) both_hi++;
      if ((wr_en_2_2 || wr_en_2_1) && prev_wr) consec++;
      if (done_o) done_cnt++;
      if (done_o && !(wr_en_2_2 || wr_en_2_1)) done_alone++;
      if (track_busy && !busy_o) busy_drop++;
      prev_wr = wr_en_2_2 || wr_en_2_1;
    end else begin
      prev_wr = 1'b0;
    end
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input int gap, input logic clr);
    host_if.host_valid_i = 1'b0;
    repeat (gap) sync();
    host_if.host_valid_i = 1'b1;
    host_if.host_data_i  = d;
    err_clr_i            = clr;
    sync();
    host_if.host_valid_i = 1'b0;
    err_clr_i            = 1'b0;
  endtask

  function automatic logic [31:0] mk_hdr(input logic [1:0] t, input logic [1:0] a,
                                         input logic [7:0] s, input logic [7:0] n);
    return {t, a, s, n, 12'h000};
  endfunction

  // One whole command: header, its 2*N data beats (if any) and the model update.
  task automatic apply_stimulus(input logic [1:0] t, input logic [1:0] a, input logic [7:0] s,
                                input logic [7:0] n, input int gmin, input int gmax);
    logic [31:0] lo, hi;
    int lim;
    bit legal;
    lim   = (t == 2'd0) ? NS22 : NS21;
    legal = (t < 2'd2) && (n != 8'd0) && (int'(s) + int'(n) <= lim);
    send_beat({t, a, s, n, 12'($urandom)}, $urandom_range(gmax, gmin), 1'b0);
    if (legal) track_busy = 1'b1;
    else       exp_err = 1'b1;
    for (int i = 0; i < int'(n); i++) begin
      lo = $urandom;
      hi = $urandom;
      send_beat(lo, $urandom_range(gmax, gmin), 1'b0);
      send_beat(hi, $urandom_range(gmax, gmin), 1'b0);
      if (legal) exp_q.push_back(wr_t'{t[0], 8'(int'(s) + i), a, {hi, lo}});
    end
    track_busy = 1'b0;
    if (legal) exp_done++;
    repeat (3) sync();
  endtask

  task automatic compare_all(input string tag);
    check_output({tag, ".nwr"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check_output({tag, ".loc"}, {53'b0, obs_q[i].tgt, obs_q[i].sel, obs_q[i].addr},
                   {53'b0, exp_q[i].tgt, exp_q[i].sel, exp_q[i].addr});
      check_output({tag, ".cfg"}, obs_q[i].cfg, exp_q[i].cfg);
    end
    check_output({tag, ".done"}, 64'(done_cnt), 64'(exp_done));
    check_output({tag, ".anom"}, {both_hi[15:0], consec[15:0], done_alone[15:0], busy_drop[15:0]}, 64'd0);
    check_output({tag, ".err"}, 64'(err_o), 64'(exp_err));
    obs_q.delete();
    exp_q.delete();
    done_cnt = 0; exp_done = 0; both_hi = 0; consec = 0; done_alone = 0; busy_drop = 0;
  endtask

  task automatic clear_err();
    err_clr_i = 1'b1;
    sync();
    err_clr_i = 1'b0;
    exp_err   = 1'b0;
  endtask

  initial begin
    host_if.host_valid_i = 1'b0;
    host_if.host_data_i  = '0;
    #3;
    check_output("reset.ctl", {58'b0, host_if.host_ready_o, busy_o, done_o, err_o, wr_en_2_2, wr_en_2_1}, 64'd0);
    check_output("reset.loc", {48'b0, sram_sel_2_2, wr_addr_2_2, sram_sel_2_1, wr_addr_2_1}, 64'd0);
    check_output("reset.cfg", wr_cfg_2_2 | wr_cfg_2_1, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sync();
    check_output("ready.up", 64'(host_if.host_ready_o), 64'd1);

    $display("[TB] single write, cycle exact");
    send_beat(mk_hdr(2'd0, 2'd2, 8'd5, 8'd1), 0, 1'b0);
    check_output("single.busy", 64'(busy_o), 64'd1);
    send_beat(32'h11112222, 0, 1'b0);
    send_beat(32'hAAAABBBB, 0, 1'b0);
    check_output("single.en", {62'b0, wr_en_2_2, wr_en_2_1}, 64'b10);
    check_output("single.loc", {54'b0, sram_sel_2_2, wr_addr_2_2}, {54'b0, 8'd5, 2'd2});
    check_output("single.cfg", wr_cfg_2_2, 64'hAAAABBBB11112222);
    check_output("single.done", 64'(done_o), 64'd1);
    sync();
    check_output("single.hold", {wr_en_2_2, done_o, sram_sel_2_2, wr_cfg_2_2[31:0]},
                 {1'b0, 1'b0, 8'd5, 32'h11112222});
    sync();
    check_output("single.idle", 64'(busy_o), 64'd0);
    exp_q.push_back(wr_t'{1'b0, 8'd5, 2'd2, 64'hAAAABBBB11112222});
    exp_done = 1;
    compare_all("single");

    $display("[TB] burst with gaps");
    apply_stimulus(2'd1, 2'd1, 8'd7, 8'd3, 2, 2);
    compare_all("burst");

    $display("[TB] illegal target then legal write");
    apply_stimulus(2'd3, 2'd0, 8'd0, 8'd2, 0, 1);
    apply_stimulus(2'd0, 2'd3, 8'd200, 8'd1, 0, 0);
    compare_all("illegal");

    $display("[TB] range overflow and zero count");
    apply_stimulus(2'd1, 2'd0, 8'd9, 8'd2, 0, 0);
    apply_stimulus(2'd1, 2'd0, 8'd0, 8'd0, 0, 0);
    check_output("zero.idle", 64'(busy_o), 64'd0);
    apply_stimulus(2'd1, 2'd2, 8'd9, 8'd1, 0, 0);
    apply_stimulus(2'd0, 2'd1, 8'd220, 8'd4, 0, 0);
    compare_all("range");

    $display("[TB] reset mid-burst");
    clear_err();
    send_beat(mk_hdr(2'd0, 2'd1, 8'd100, 8'd4), 0, 1'b0);
    send_beat(32'h01234567, 0, 1'b0);
    send_beat(32'h89ABCDEF, 0, 1'b0);
    send_beat(32'h55555555, 0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_output("midrst.ctl", {58'b0, host_if.host_ready_o, busy_o, done_o, err_o, wr_en_2_2, wr_en_2_1}, 64'd0);
    check_output("midrst.cfg", {sram_sel_2_2, wr_addr_2_2, wr_cfg_2_2[53:0]}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sync();
    check_output("midrst.ready", {62'b0, host_if.host_ready_o, busy_o}, 64'b10);
    exp_q.push_back(wr_t'{1'b0, 8'd100, 2'd1, 64'h89ABCDEF01234567});
    compare_all("midrst");
    apply_stimulus(2'd0, 2'd2, 8'd0, 8'd2, 0, 1);
    compare_all("postrst");

    $display("[TB] set beats clear");
    send_beat(mk_hdr(2'd2, 2'd0, 8'd0, 8'd0), 0, 1'b1);
    sync();
    check_output("setclr.set", 64'(err_o), 64'd1);
    clear_err();
    check_output("setclr.clr", 64'(err_o), 64'd0);

    $display("[TB] randomized commands");
    for (int k = 0; k < 24; k++) begin
      logic [1:0] t;
      logic [7:0] s, n;
      t = ($urandom_range(9, 0) < 8) ? 2'($urandom_range(1, 0)) : 2'($urandom_range(3, 2));
      n = 8'($urandom_range(4, 0));
      s = (t == 2'd0) ? 8'($urandom_range(223, 215)) : 8'($urandom_range(10, 0));
      if (k % 3 == 0) clear_err();
      apply_stimulus(t, 2'($urandom), s, n, 0, 2);
      compare_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
